// File: rtl/gumnut_bus_pkg.sv
// Shared bus types for the two-master memory arbiter.
// Holds the arbiter state encoding and the one-hot grant codes.
package gumnut_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic logic [1:0] gnt_of(arb_state_t s);
    unique case (s)
      GNT0:    return GNT_M0;
      GNT1:    return GNT_M1;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Stall counter for the arbiter: counts unacked strobe cycles.
// Ports: clk, rst (async low), clr, inc in; tmo out at TIMEOUT.
module arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tmo
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != W'(TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (cnt == W'(TIMEOUT));

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master Wishbone arbiter, grant locked per bus cycle.
// Ports: m0_*/m1_* masters, s_* slave, gnt_o, err_o; ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import gumnut_bus_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic [1:0]        gnt_o,
  output logic              err_o
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  arb_state_t state, state_n;
  logic [1:0] gnt_q;
  logic       last_gnt, last_n;
  logic       own_cyc;
  logic       req0, req1;
  logic       tmo;

  // A zero own_cyc covers both IDLE and an owner ending its cycle.
  assign own_cyc = (gnt_q[0] & m0_cyc_i) | (gnt_q[1] & m1_cyc_i);

`ifdef ARB_TIMEOUT_EN
  logic [1:0] blk;
  logic       wd_tmo;
  logic       gnt_chg;

  assign gnt_chg = (gnt_of(state_n) != gnt_q);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(s_ack_i | gnt_chg),
    .inc((gnt_q != GNT_NONE) & s_stb_o & ~s_ack_i),
    .tmo(wd_tmo)
  );

  assign tmo   = wd_tmo & ~s_ack_i & (gnt_q != GNT_NONE);
  assign err_o = tmo;
  assign req0  = m0_cyc_i & ~blk[0];
  assign req1  = m1_cyc_i & ~blk[1];

  // A timed-out master stays locked out until it releases cyc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk <= 2'b00;
    end else begin
      blk[0] <= (blk[0] & m0_cyc_i) | (tmo & gnt_q[0]);
      blk[1] <= (blk[1] & m1_cyc_i) | (tmo & gnt_q[1]);
    end
  end
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
  assign req0  = m0_cyc_i;
  assign req1  = m1_cyc_i;
`endif

  always_comb begin
    state_n = state;
    last_n  = last_gnt;
    if (tmo) begin
      state_n = IDLE;
      last_n  = gnt_q[1];
    end else if (!own_cyc) begin
      if (req0 && (!req1 || last_gnt)) begin
        state_n = GNT0;
        last_n  = 1'b0;
      end else if (req1) begin
        state_n = GNT1;
        last_n  = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_q    <= GNT_NONE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_n;
      gnt_q    <= gnt_of(state_n);
      last_gnt <= last_n;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    unique case (1'b1)
      gnt_q[0]: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      gnt_q[1]: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign gnt_o    = gnt_q;
  assign m0_ack_o = s_ack_i & gnt_q[0];
  assign m1_ack_o = s_ack_i & gnt_q[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with master models and scoreboard.
// Covers grant, round-robin, lock, writes, reset, ARB_TIMEOUT_EN.
module tb_wb_mem_arbiter;

  typedef struct {
    int          beats;
    logic [11:0] adr;
    logic        we;
    logic [17:0] dat;
  } txn_t;

  typedef struct {
    logic [11:0] adr;
    logic        we;
    logic [17:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [11:0] m0_adr_i;
  logic [17:0] m0_dat_i;
  logic        m0_ack_o;
  logic [17:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [11:0] m1_adr_i;
  logic [17:0] m1_dat_i;
  logic        m1_ack_o;
  logic [17:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [11:0] s_adr_o;
  logic [17:0] s_dat_o;
  logic        s_ack_i;
  logic [17:0] s_dat_i;
  logic [1:0]  gnt_o;
  logic        err_o;

  logic ack_en;

  // Zero-wait slave returning a pattern derived from the address.
  assign s_ack_i = ack_en & s_stb_o;
  assign s_dat_i = {6'h2A, s_adr_o};

  wb_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  txn_t mq[2][$];
  exp_t sb[2][$];
  txn_t cur[2];
  bit   act[2];
  bit   gap[2];
  int   left[2];
  logic [1:0] ack_log[$];

  logic [1:0] sn_gnt;
  logic       sn_ack0, sn_ack1, sn_scyc, sn_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      act[m]  = 1'b0;
      gap[m]  = 1'b0;
      left[m] = 0;
      mq[m].delete();
      sb[m].delete();
    end
    ack_log.delete();
  endtask

  task automatic abort_master(input int m);
    act[m]  = 1'b0;
    gap[m]  = 1'b1;
    left[m] = 0;
    sb[m].delete();
  endtask

  task automatic apply_pins();
    logic [11:0] a0, a1;
    a0 = cur[0].adr + 12'(cur[0].beats - left[0]);
    a1 = cur[1].adr + 12'(cur[1].beats - left[1]);
    m0_cyc_i = act[0];
    m0_stb_i = act[0];
    m0_we_i  = act[0] & cur[0].we;
    m0_adr_i = act[0] ? a0 : 12'h0;
    m0_dat_i = act[0] ? cur[0].dat : 18'h0;
    m1_cyc_i = act[1];
    m1_stb_i = act[1];
    m1_we_i  = act[1] & cur[1].we;
    m1_adr_i = act[1] ? a1 : 12'h0;
    m1_dat_i = act[1] ? cur[1].dat : 18'h0;
  endtask

  // A master drops cyc for one cycle between its bus cycles.
  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      if (act[m] && left[m] == 0) begin
        act[m] = 1'b0;
        gap[m] = 1'b1;
      end else if (!act[m] && gap[m]) begin
        gap[m] = 1'b0;
      end else if (!act[m] && mq[m].size() > 0) begin
        cur[m]  = mq[m].pop_front();
        act[m]  = 1'b1;
        left[m] = cur[m].beats;
        for (int i = 0; i < cur[m].beats; i++)
          sb[m].push_back('{adr: cur[m].adr + 12'(i),
                            we: cur[m].we, dat: cur[m].dat});
      end
    end
    apply_pins();
  endtask

  task automatic monitor();
    logic        ackm;
    logic [17:0] datm;
    exp_t        e;
    sn_gnt  = gnt_o;
    sn_ack0 = m0_ack_o;
    sn_ack1 = m1_ack_o;
    sn_scyc = s_cyc_o;
    sn_err  = err_o;
    if (m0_ack_o || m1_ack_o)
      ack_log.push_back({m1_ack_o, m0_ack_o});
    for (int m = 0; m < 2; m++) begin
      ackm = (m == 0) ? m0_ack_o : m1_ack_o;
      datm = (m == 0) ? m0_dat_o : m1_dat_o;
      if (ackm) begin
        if (sb[m].size() == 0) begin
          chk($sformatf("spurious_ack_m%0d", m), 32'd1, 32'd0);
        end else begin
          e = sb[m].pop_front();
          chk($sformatf("ack_gnt_m%0d", m), 32'(gnt_o), 32'(1 << m));
          chk($sformatf("s_adr_m%0d", m), 32'(s_adr_o), 32'(e.adr));
          chk($sformatf("s_we_m%0d", m), 32'(s_we_o), 32'(e.we));
          if (e.we)
            chk($sformatf("s_dat_m%0d", m), 32'(s_dat_o), 32'(e.dat));
          else
            chk($sformatf("rd_dat_m%0d", m), 32'(datm),
                32'({6'h2A, e.adr}));
          if (left[m] > 0) left[m]--;
        end
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy();
    return act[0] | act[1] | gap[0] | gap[1] |
           (mq[0].size() > 0) | (mq[1].size() > 0);
  endfunction

  task automatic run(input int max);
    int n = 0;
    while (busy() && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(busy()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_model();
    apply_pins();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    ack_en = 1'b1;
    cur[0] = '{beats: 0, adr: 12'h0, we: 1'b0, dat: 18'h0};
    cur[1] = cur[0];
    do_reset();

    // Single master, single beat.
    mq[0].push_back('{beats: 1, adr: 12'h005, we: 1'b0, dat: 18'h0});
    step();
    chk("t1_gnt_wait", 32'(sn_gnt), 32'd0);
    step();
    chk("t1_gnt", 32'(sn_gnt), 32'b01);
    chk("t1_ack0", 32'(sn_ack0), 32'd1);
    chk("t1_ack1", 32'(sn_ack1), 32'd0);
    run(20);
    step();
    chk("t1_idle", 32'(sn_gnt), 32'd0);

    // Simultaneous requests straight out of reset.
    do_reset();
    mq[0].push_back('{beats: 1, adr: 12'h010, we: 1'b0, dat: 18'h0});
    mq[1].push_back('{beats: 1, adr: 12'h020, we: 1'b0, dat: 18'h0});
    step();
    chk("t2_gnt_wait", 32'(sn_gnt), 32'd0);
    step();
    chk("t2_first", 32'(sn_gnt), 32'b01);
    step();
    chk("t2_hold", 32'(sn_gnt), 32'b01);
    step();
    chk("t2_handover", 32'(sn_gnt), 32'b10);
    chk("t2_ack1", 32'(sn_ack1), 32'd1);
    run(20);

    // Both masters request continuously.
    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      mq[0].push_back('{beats: 1, adr: 12'(12'h040 + i), we: 1'b0,
                        dat: 18'h0});
      mq[1].push_back('{beats: 1, adr: 12'(12'h080 + i), we: 1'b0,
                        dat: 18'h0});
    end
    run(80);
    chk("t3_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      chk($sformatf("t3_rr_%0d", i), 32'(ack_log[i]),
          (i % 2 == 0) ? 32'b01 : 32'b10);

    // Locked three-beat burst from m1 with m0 waiting.
    ack_log.delete();
    mq[1].push_back('{beats: 3, adr: 12'h100, we: 1'b0, dat: 18'h0});
    step();
    mq[0].push_back('{beats: 1, adr: 12'h200, we: 1'b0, dat: 18'h0});
    run(30);
    chk("t4_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk($sformatf("t4_lock_%0d", i), 32'(ack_log[i]),
          (i < 3) ? 32'b10 : 32'b01);

    // Write pass-through from m1.
    ack_log.delete();
    mq[1].push_back('{beats: 1, adr: 12'h0A3, we: 1'b1,
                      dat: 18'h0003C});
    run(20);
    chk("t5_count", 32'(ack_log.size()), 32'd1);

    // Asynchronous reset in the middle of a granted cycle.
    ack_en = 1'b0;
    mq[0].push_back('{beats: 4, adr: 12'h300, we: 1'b0, dat: 18'h0});
    step();
    step();
    chk("t6_gnt", 32'(sn_gnt), 32'b01);
    chk("t6_scyc", 32'(sn_scyc), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_scyc", 32'(s_cyc_o), 32'd0);
    chk("t6_async_gnt", 32'(gnt_o), 32'd0);
    chk("t6_async_ack", 32'(m0_ack_o), 32'd0);
    clear_model();
    apply_pins();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Slave never acks.
    mq[0].push_back('{beats: 1, adr: 12'h3FF, we: 1'b0, dat: 18'h0});
    step();
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("t7_err_c%0d", i), 32'(sn_err),
          (i == 16) ? 32'd1 : 32'd0);
      chk($sformatf("t7_gnt_c%0d", i), 32'(sn_gnt), 32'b01);
    end
    step();
    chk("t7_revoked", 32'(sn_gnt), 32'd0);
    chk("t7_err_pulse", 32'(sn_err), 32'd0);
    step();
    chk("t7_blocked_a", 32'(sn_gnt), 32'd0);
    step();
    chk("t7_blocked_b", 32'(sn_gnt), 32'd0);
`else
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("t7_hold_c%0d", i), 32'(sn_gnt), 32'b01);
      chk($sformatf("t7_err_c%0d", i), 32'(sn_err), 32'd0);
    end
`endif
    abort_master(0);
    ack_en = 1'b1;
    ack_log.delete();
    mq[0].push_back('{beats: 1, adr: 12'h123, we: 1'b0, dat: 18'h0});
    run(20);
    chk("t7_recover", 32'(ack_log.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
